atm_fsm_param: RTL and testbench

Parametrised ATM controller, the successor to the fixed 4-bit-PIN / 3-bit-balance cashier FSM. It sequences power-on, PIN authentication, withdrawal and balance query. Widths, PIN value, cash stock, withdrawal step and display-hold time are generic. It adds failed-attempt counting, explicit logout and insufficient-funds denial, and sits between the keypad/push-button front end and the 7-segment display drivers.

---
 rtl/atm_fsm_param_if.sv | 35 +++
 rtl/atm_fsm_param.sv | 149 ++++++++++++++
 tb/tb_atm_fsm_param.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/atm_fsm_param_if.sv
// Front-end bundle between keypad/buttons and the ATM controller.
// master drives requests, slave (the controller) drives status.
interface atm_fsm_param_if #(
  parameter int PIN_W = 4,
  parameter int BAL_W = 3,
  parameter int FC_W  = 2
);
  logic             on;
  logic             push1;
  logic             push2;
  logic             cancel;
  logic             enter;
  logic [PIN_W-1:0] password;
  logic             powered;
  logic             logged_in;
  logic             wd_pulse;
  logic             denied;
  logic             show_balance;
  logic [BAL_W-1:0] balance;
  logic             empty;
  logic [FC_W-1:0]  fail_cnt;
  logic             locked;

  modport master (
    output on, push1, push2, cancel, enter, password,
    input  powered, logged_in, wd_pulse, denied,
    input  show_balance, balance, empty, fail_cnt, locked
  );

  modport slave (
    input  on, push1, push2, cancel, enter, password,
    output powered, logged_in, wd_pulse, denied,
    output show_balance, balance, empty, fail_cnt, locked
  );
endinterface

// File: rtl/atm_fsm_param.sv
// Parametrised ATM controller: power, PIN auth, withdraw, query.
// Define ATM_LOCKOUT_EN to lock the machine after MAX_TRIES bad PINs.
module atm_fsm_param #(
  parameter int               PIN_W     = 4,
  parameter logic [PIN_W-1:0] PIN_VALUE = 4'b1001,
  parameter int               BAL_W     = 3,
  parameter int               BAL_INIT  = 7,
  parameter int               WD_AMOUNT = 1,
  parameter int               HOLD_CYC  = 2,
  parameter int               MAX_TRIES = 3,
  parameter int               FC_W      = $clog2(MAX_TRIES+1)
) (
  input logic                clock,
  input logic                reset,
  atm_fsm_param_if.slave     bus
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [BAL_W:0]   WDA   = (BAL_W+1)'(WD_AMOUNT);
  localparam logic [BAL_W-1:0] BINIT = BAL_W'(BAL_INIT);
  localparam logic [FC_W-1:0]  MAXF  = FC_W'(MAX_TRIES);
  localparam logic [FC_W-1:0]  ONEF  = FC_W'(1);
  localparam logic [HW-1:0]    HLOAD = HW'(HOLD_CYC-1);
  localparam logic [HW-1:0]    ONEH  = HW'(1);

  typedef enum logic [2:0] {
    OFF, IDLE, AUTH, WITHDRAW, QUERY, LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [BAL_W-1:0] stock_q, stock_d;
  logic [FC_W-1:0]  fail_q, fail_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             wd_d, den_d;
  logic             powered_q, logged_q, wd_q;
  logic             den_q, show_q, locked_q;

  logic can_wd, both, p1, p2;

  // compare in BAL_W+1 bits so the stock can never wrap
  assign can_wd = {1'b0, stock_q} >= WDA;
  assign both   = !bus.cancel && bus.push1 && bus.push2;
  assign p1     = !bus.cancel && bus.push1 && !bus.push2;
  assign p2     = !bus.cancel && bus.push2 && !bus.push1;

  always_comb begin
    state_d = state_q;
    stock_d = stock_q;
    fail_d  = fail_q;
    hold_d  = hold_q;
    wd_d    = 1'b0;
    den_d   = 1'b0;
    if (!bus.on) begin
      state_d = OFF;
      fail_d  = '0;
    end else begin
      unique case (state_q)
        OFF: state_d = IDLE;
        IDLE: begin
          if (bus.enter) begin
            if (bus.password == PIN_VALUE) begin
              state_d = AUTH;
              fail_d  = '0;
            end else if (fail_q != MAXF) begin
              fail_d = fail_q + ONEF;
            end
          end
`ifdef ATM_LOCKOUT_EN
          if (fail_q == MAXF) begin
            state_d = LOCKED;
            fail_d  = fail_q;
          end
`endif
        end
        AUTH: begin
          unique case (1'b1)
            bus.cancel: state_d = IDLE;
            both: ;
            p1: begin
              if (can_wd) begin
                state_d = WITHDRAW;
                stock_d = stock_q - WDA[BAL_W-1:0];
                hold_d  = HLOAD;
                wd_d    = 1'b1;
              end else begin
                den_d = 1'b1;
              end
            end
            p2: begin
              state_d = QUERY;
              hold_d  = HLOAD;
            end
            default: ;
          endcase
        end
        WITHDRAW, QUERY: begin
          if (hold_q == '0) state_d = AUTH;
          else              hold_d  = hold_q - ONEH;
        end
        LOCKED: ;
        default: state_d = OFF;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OFF;
      stock_q   <= BINIT;
      fail_q    <= '0;
      hold_q    <= '0;
      powered_q <= 1'b0;
      logged_q  <= 1'b0;
      wd_q      <= 1'b0;
      den_q     <= 1'b0;
      show_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stock_q   <= stock_d;
      fail_q    <= fail_d;
      hold_q    <= hold_d;
      powered_q <= state_d != OFF;
      logged_q  <= state_d == AUTH ||
                   state_d == WITHDRAW ||
                   state_d == QUERY;
      wd_q      <= wd_d;
      den_q     <= den_d;
      show_q    <= state_d == QUERY;
`ifdef ATM_LOCKOUT_EN
      locked_q  <= state_d == LOCKED;
`else
      locked_q  <= 1'b0;
`endif
    end
  end

  assign bus.powered      = powered_q;
  assign bus.logged_in    = logged_q;
  assign bus.wd_pulse     = wd_q;
  assign bus.denied       = den_q;
  assign bus.show_balance = show_q;
  assign bus.balance      = show_q ? stock_q : '0;
  assign bus.empty        = !can_wd;
  assign bus.fail_cnt     = fail_q;
  assign bus.locked       = locked_q;

endmodule

// File: tb/tb_atm_fsm_param.sv
// Directed bench for atm_fsm_param with default parameters.
// Expectations follow ATM_LOCKOUT_EN when it is defined.
module tb_atm_fsm_param;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  atm_fsm_param_if #(.PIN_W(4), .BAL_W(3), .FC_W(2)) bus ();

  atm_fsm_param dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pin(input logic [3:0] p);
    bus.enter    = 1'b1;
    bus.password = p;
    step();
    bus.enter    = 1'b0;
    bus.password = 4'b0000;
  endtask

  task automatic withdraw(input logic exp_empty);
    bus.push1 = 1'b1;
    step();
    check("wd_pulse", bus.wd_pulse, 1);
    check("wd_empty", bus.empty, exp_empty);
    bus.push1 = 1'b0;
    step();
    check("wd_once", bus.wd_pulse, 0);
    check("wd_logged", bus.logged_in, 1);
    step();
  endtask

  task automatic power_login();
    bus.on = 1'b1;
    step();
    pin(4'b1001);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.on = 1'b0;
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
    bus.cancel = 1'b0;
    bus.enter = 1'b0;
    bus.password = 4'b0000;
    reset = 1'b1;
    #3;
    check("rst_powered", bus.powered, 0);
    check("rst_fail", bus.fail_cnt, 0);
    check("rst_empty", bus.empty, 0);
    check("rst_balance", bus.balance, 0);
    check("rst_locked", bus.locked, 0);
    #4 reset = 1'b0;

    // power off: buttons have no effect
    bus.push1 = 1'b1;
    bus.push2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("off_powered", bus.powered, 0);
      check("off_wd", bus.wd_pulse, 0);
      bus.push2 = ~bus.push2;
    end
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
    bus.on = 1'b1;
    step();
    check("on_powered", bus.powered, 1);
    check("on_logged", bus.logged_in, 0);

    pin(4'b0100);
    check("bad1_fail", bus.fail_cnt, 1);
    check("bad1_logged", bus.logged_in, 0);
    pin(4'b0110);
    check("bad2_fail", bus.fail_cnt, 2);
    pin(4'b1001);
    check("good_logged", bus.logged_in, 1);
    check("good_fail", bus.fail_cnt, 0);

    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("cancel_logged", bus.logged_in, 0);
    check("cancel_powered", bus.powered, 1);

    pin(4'b0000);
    pin(4'b0001);
    pin(4'b0010);
    check("bad3_fail", bus.fail_cnt, 3);
    step();
`ifdef ATM_LOCKOUT_EN
    check("lock_locked", bus.locked, 1);
    pin(4'b1001);
    check("lock_ignore", bus.logged_in, 0);
    check("lock_stays", bus.locked, 1);
    bus.on = 1'b0;
    step();
    check("lock_off_pwr", bus.powered, 0);
    check("lock_off_fail", bus.fail_cnt, 0);
    bus.on = 1'b1;
    step();
    check("relock_locked", bus.locked, 0);
    check("relock_pwr", bus.powered, 1);
    pin(4'b1001);
`else
    check("nolock_locked", bus.locked, 0);
    pin(4'b0111);
    check("sat_fail", bus.fail_cnt, 3);
    pin(4'b1001);
`endif
    check("login_logged", bus.logged_in, 1);
    check("login_fail", bus.fail_cnt, 0);

    // both buttons together: no transition
    bus.push1 = 1'b1;
    bus.push2 = 1'b1;
    step();
    bus.push1 = 1'b0;
    bus.push2 = 1'b0;
    check("both_wd", bus.wd_pulse, 0);
    check("both_show", bus.show_balance, 0);
    check("both_logged", bus.logged_in, 1);
    step();

    withdraw(1'b0);
    withdraw(1'b0);

    bus.push2 = 1'b1;
    step();
    bus.push2 = 1'b0;
    check("q1_show", bus.show_balance, 1);
    check("q1_bal", bus.balance, 5);
    step();
    check("q2_show", bus.show_balance, 1);
    check("q2_bal", bus.balance, 5);
    step();
    check("q3_show", bus.show_balance, 0);
    check("q3_bal", bus.balance, 0);

    for (int i = 0; i < 5; i++) withdraw(i == 4);
    check("drained_empty", bus.empty, 1);

    bus.push1 = 1'b1;
    step();
    bus.push1 = 1'b0;
    check("deny_denied", bus.denied, 1);
    check("deny_wd", bus.wd_pulse, 0);
    check("deny_logged", bus.logged_in, 1);
    step();
    check("deny_once", bus.denied, 0);

    // power loss mid-withdraw keeps the committed decrement
    reset = 1'b1;
    #2 reset = 1'b0;
    power_login();
    bus.push1 = 1'b1;
    step();
    check("pl_wd", bus.wd_pulse, 1);
    bus.push1 = 1'b0;
    bus.on = 1'b0;
    step();
    check("pl_powered", bus.powered, 0);
    check("pl_wd2", bus.wd_pulse, 0);
    power_login();
    bus.push2 = 1'b1;
    step();
    bus.push2 = 1'b0;
    check("pl_bal", bus.balance, 6);
    step();
    step();

    // async reset mid-withdraw
    bus.push1 = 1'b1;
    step();
    bus.push1 = 1'b0;
    check("ar_wd", bus.wd_pulse, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_powered", bus.powered, 0);
    check("ar_logged", bus.logged_in, 0);
    check("ar_wd0", bus.wd_pulse, 0);
    check("ar_empty", bus.empty, 0);
    check("ar_fail", bus.fail_cnt, 0);
    #1 reset = 1'b0;
    power_login();
    bus.push2 = 1'b1;
    step();
    bus.push2 = 1'b0;
    check("ar_stock", bus.balance, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
